// File: rtl/pattern_serializer_if.sv
// pattern_serializer_if
//   Bundles the request side (Start/Data/Len/Repeat) and the serial output
//   side (X/XValid/Busy/Done/state1) of the pattern serializer.
//   master : the requester / observer (drives Start, Data, Len, Repeat)
//   slave  : the serializer itself (drives X, XValid, Busy, Done, state1)
interface pattern_serializer_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
);
  logic             Start;
  logic [WIDTH-1:0] Data;
  logic [LEN_W-1:0] Len;
  logic [REP_W-1:0] Repeat;
  logic             X;
  logic             XValid;
  logic             Busy;
  logic             Done;
  logic [1:0]       state1;

  modport master (
    output Start, Data, Len, Repeat,
    input  X, XValid, Busy, Done, state1
  );

  modport slave (
    input  Start, Data, Len, Repeat,
    output X, XValid, Busy, Done, state1
  );
endinterface

// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Latches a parallel pattern on Start and shifts it out LSB first, one bit
//   per clock on X, for Len bits per pass and Repeat passes, with a single
//   idle gap cycle between passes and a one-cycle Done pulse at the end.
//   Moore machine: every output decodes from registered state only.
// Ports
//   Clk  : clock, all state changes on the rising edge
//   Clr  : asynchronous active-high reset (aborts any transfer, no Done)
//   bus  : slave side of pattern_serializer_if
//          in  Start, Data[WIDTH], Len[LEN_W], Repeat[REP_W]
//          out X, XValid, Busy, Done, state1[2]
module pattern_serializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic                 Clk,
  input  logic                 Clr,
  pattern_serializer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_reg,   state_next;
  logic [WIDTH-1:0] shreg_reg,   shreg_next;
  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic [LEN_W-1:0] len_reg,     len_next;
  logic [LEN_W-1:0] bitcnt_reg,  bitcnt_next;
  logic [REP_W-1:0] passcnt_reg, passcnt_next;

  logic [LEN_W-1:0] len_clamped;
  logic [REP_W-1:0] rep_eff;

  // Normalise the request so the counters start at >= 1 and never wrap.
  always_comb begin
    len_clamped = bus.Len;
    if (bus.Len == '0)
      len_clamped = LEN_W'(1);
    else if (bus.Len > LEN_W'(WIDTH))
      len_clamped = LEN_W'(WIDTH);
  end

  assign rep_eff = (bus.Repeat == '0) ? REP_W'(1) : bus.Repeat;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      pattern_reg <= '0;
      len_reg     <= '0;
      bitcnt_reg  <= '0;
      passcnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      bitcnt_reg  <= bitcnt_next;
      passcnt_reg <= passcnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    bitcnt_next  = bitcnt_reg;
    passcnt_next = passcnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          // Keep a private copy of the request so later input changes
          // cannot disturb the transfer or its repeats.
          pattern_next = bus.Data;
          shreg_next   = bus.Data;
          len_next     = len_clamped;
          bitcnt_next  = len_clamped;
          passcnt_next = rep_eff;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        if (bitcnt_reg == LEN_W'(1)) begin
          passcnt_next = passcnt_reg - REP_W'(1);
          if (passcnt_reg == REP_W'(1)) begin
            shreg_next  = {1'b0, shreg_reg[WIDTH-1:1]};
            bitcnt_next = '0;
            state_next  = DONE;
          end else begin
            // Rearm for the next pass during the gap cycle.
            shreg_next  = pattern_reg;
            bitcnt_next = len_reg;
            state_next  = GAP;
          end
        end else begin
          shreg_next  = {1'b0, shreg_reg[WIDTH-1:1]};
          bitcnt_next = bitcnt_reg - LEN_W'(1);
        end
      end

      GAP: begin
        state_next = SHIFT;
      end

      DONE: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.XValid = (state_reg == SHIFT);
  assign bus.X      = (state_reg == SHIFT) & shreg_reg[0];
  assign bus.Busy   = (state_reg != IDLE);
  assign bus.Done   = (state_reg == DONE);
  assign bus.state1 = state_reg;

endmodule
